// File: rtl/alu_issue_if.sv
`default_nettype none
// ============================================================================
// Module : alu_issue_if
// Brief  : Instruction-in / ALU-operands-out handshake bundle for alu_issue.
// Rev    : 1.0
// ============================================================================
interface alu_issue_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] alu_a;
    logic [XLEN-1:0] alu_b;
    logic [3:0]      alu_control;
    logic            illegal;

    // master: the environment (upstream decode plus downstream execute)
    modport master (
        output in_valid, instr, pc, rs1_data, rs2_data, out_ready,
        input  in_ready, out_valid, alu_a, alu_b, alu_control, illegal
    );

    // slave: the issue block itself
    modport slave (
        input  in_valid, instr, pc, rs1_data, rs2_data, out_ready,
        output in_ready, out_valid, alu_a, alu_b, alu_control, illegal
    );
endinterface

`default_nettype wire

// File: rtl/alu_issue.sv
`default_nettype none
// ============================================================================
// Module : alu_issue
// Brief  : RV32I decode to ALU operands/control, behind a 2-entry skid buffer.
// Rev    : 1.0
// ============================================================================
module alu_issue #(
    parameter int XLEN = 32
) (
    input  wire logic  clk,
    input  wire logic  rst,
    alu_issue_if.slave bus
);
    localparam int c_PW = 2 * XLEN + 5;

    localparam logic [3:0] c_ALU_ADD   = 4'b0000;
    localparam logic [3:0] c_ALU_SUB   = 4'b0001;
    localparam logic [3:0] c_ALU_AND   = 4'b0010;
    localparam logic [3:0] c_ALU_OR    = 4'b0011;
    localparam logic [3:0] c_ALU_XOR   = 4'b0100;
    localparam logic [3:0] c_ALU_SLL   = 4'b0101;
    localparam logic [3:0] c_ALU_SRL   = 4'b0110;
    localparam logic [3:0] c_ALU_SRA   = 4'b0111;
    localparam logic [3:0] c_ALU_SLT   = 4'b1000;
    localparam logic [3:0] c_ALU_SLTU  = 4'b1001;
    localparam logic [3:0] c_ALU_PASSB = 4'b1010;

    localparam logic [6:0] c_OPC_OP     = 7'b0110011;
    localparam logic [6:0] c_OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] c_OPC_LUI    = 7'b0110111;
    localparam logic [6:0] c_OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] c_OPC_JAL    = 7'b1101111;
    localparam logic [6:0] c_OPC_JALR   = 7'b1100111;
    localparam logic [6:0] c_OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OPC_STORE  = 7'b0100011;
    localparam logic [6:0] c_OPC_BRANCH = 7'b1100011;

    localparam logic [6:0] c_F7_BASE = 7'b0000000;
    localparam logic [6:0] c_F7_ALT  = 7'b0100000;

    function automatic logic [3:0] f3_to_ctrl(input logic [2:0] f3);
        logic [3:0] r;
        case (f3)
            3'b000:  r = c_ALU_ADD;
            3'b001:  r = c_ALU_SLL;
            3'b010:  r = c_ALU_SLT;
            3'b011:  r = c_ALU_SLTU;
            3'b100:  r = c_ALU_XOR;
            3'b101:  r = c_ALU_SRL;
            3'b110:  r = c_ALU_OR;
            default: r = c_ALU_AND;
        endcase
        return r;
    endfunction

    logic [6:0]      w_opcode;
    logic [2:0]      w_funct3;
    logic [6:0]      w_funct7;
    logic [31:0]     w_imm_i;
    logic [31:0]     w_imm_s;
    logic [31:0]     w_imm_u;
    logic [31:0]     w_imm_j;
    logic [31:0]     w_shamt;
    logic [XLEN-1:0] w_a;
    logic [XLEN-1:0] w_b;
    logic [3:0]      w_ctrl;
    logic            w_ill;
    logic [c_PW-1:0] w_new_pay;

    assign w_opcode = bus.instr[6:0];
    assign w_funct3 = bus.instr[14:12];
    assign w_funct7 = bus.instr[31:25];
    assign w_imm_i  = {{20{bus.instr[31]}}, bus.instr[31:20]};
    assign w_imm_s  = {{20{bus.instr[31]}}, bus.instr[31:25], bus.instr[11:7]};
    assign w_imm_u  = {bus.instr[31:12], 12'b0};
    assign w_imm_j  = {{12{bus.instr[31]}}, bus.instr[19:12], bus.instr[20],
                       bus.instr[30:21], 1'b0};
    assign w_shamt  = {27'b0, bus.instr[24:20]};

    always_comb begin
        w_a    = '0;
        w_b    = '0;
        w_ctrl = c_ALU_ADD;
        w_ill  = 1'b0;
        case (w_opcode)
            c_OPC_OP: begin
                w_a = bus.rs1_data;
                w_b = bus.rs2_data;
                if (w_funct7 == c_F7_BASE)
                    w_ctrl = f3_to_ctrl(w_funct3);
                else if (w_funct7 == c_F7_ALT && w_funct3 == 3'b000)
                    w_ctrl = c_ALU_SUB;
                else if (w_funct7 == c_F7_ALT && w_funct3 == 3'b101)
                    w_ctrl = c_ALU_SRA;
                else
                    w_ill = 1'b1;
            end
            c_OPC_OPIMM: begin
                w_a    = bus.rs1_data;
                w_b    = w_imm_i;
                w_ctrl = f3_to_ctrl(w_funct3);
                // Only the shift forms constrain the upper immediate bits
                if (w_funct3 == 3'b001) begin
                    w_b   = w_shamt;
                    w_ill = (w_funct7 != c_F7_BASE);
                end else if (w_funct3 == 3'b101) begin
                    w_b = w_shamt;
                    if (w_funct7 == c_F7_ALT)
                        w_ctrl = c_ALU_SRA;
                    else if (w_funct7 != c_F7_BASE)
                        w_ill = 1'b1;
                end
            end
            c_OPC_LUI: begin
                w_b    = w_imm_u;
                w_ctrl = c_ALU_PASSB;
            end
            c_OPC_AUIPC: begin
                w_a = bus.pc;
                w_b = w_imm_u;
            end
            c_OPC_JAL: begin
                w_a = bus.pc;
                w_b = w_imm_j;
            end
            c_OPC_JALR: begin
                w_a   = bus.rs1_data;
                w_b   = w_imm_i;
                w_ill = (w_funct3 != 3'b000);
            end
            c_OPC_LOAD: begin
                w_a = bus.rs1_data;
                w_b = w_imm_i;
            end
            c_OPC_STORE: begin
                w_a = bus.rs1_data;
                w_b = w_imm_s;
            end
            c_OPC_BRANCH: begin
                w_a = bus.rs1_data;
                w_b = bus.rs2_data;
                case (w_funct3)
                    3'b000, 3'b001: w_ctrl = c_ALU_SUB;
                    3'b100, 3'b101: w_ctrl = c_ALU_SLT;
                    3'b110, 3'b111: w_ctrl = c_ALU_SLTU;
                    default:        w_ill  = 1'b1;
                endcase
            end
            default: w_ill = 1'b1;
        endcase
    end

    // Payload layout: {illegal, alu_control, alu_a, alu_b}
    assign w_new_pay = w_ill ? {1'b1, c_ALU_ADD, {(2*XLEN){1'b0}}}
                             : {1'b0, w_ctrl, w_a, w_b};

    logic            r_out_valid;
    logic [c_PW-1:0] r_out_pay;
    logic            r_skid_valid;
    logic [c_PW-1:0] r_skid_pay;
    logic            w_in_fire;
    logic            w_out_free;

    assign w_in_fire  = bus.in_valid && !r_skid_valid;
    // Output slot can take a new item when empty or being drained this cycle
    assign w_out_free = !r_out_valid || bus.out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid  <= 1'b0;
            r_out_pay    <= '0;
            r_skid_valid <= 1'b0;
            r_skid_pay   <= '0;
        end else if (w_out_free) begin
            if (r_skid_valid) begin
                r_out_valid  <= 1'b1;
                r_out_pay    <= r_skid_pay;
                r_skid_valid <= 1'b0;
            end else if (w_in_fire) begin
                r_out_valid <= 1'b1;
                r_out_pay   <= w_new_pay;
            end else begin
                r_out_valid <= 1'b0;
            end
        end else if (w_in_fire) begin
            r_skid_valid <= 1'b1;
            r_skid_pay   <= w_new_pay;
        end
    end

    assign bus.in_ready    = !r_skid_valid;
    assign bus.out_valid   = r_out_valid;
    assign bus.illegal     = r_out_pay[c_PW-1];
    assign bus.alu_control = r_out_pay[c_PW-2 -: 4];
    assign bus.alu_a       = r_out_pay[2*XLEN-1 -: XLEN];
    assign bus.alu_b       = r_out_pay[XLEN-1:0];
endmodule

`default_nettype wire

// File: tb/tb_alu_issue.sv
`default_nettype none
// ============================================================================
// Module : tb_alu_issue
// Brief  : Scoreboard bench for alu_issue using hand-decoded directed vectors.
// Rev    : 1.0
// ============================================================================
module tb_alu_issue;
    logic clk;
    logic rst;

    alu_issue_if #(.XLEN(32)) ifc();

    alu_issue #(.XLEN(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  ctrl;
        logic        ill;
    } vec_t;

    vec_t        tbl[$];
    logic [68:0] sb[$];     // {illegal, ctrl, a, b}
    int          n_checks = 0;
    int          n_fail   = 0;
    int          ready_mode = 0;   // 0: high, 1: low, 2: random

    localparam logic [31:0] R1 = 32'h1111_1111;
    localparam logic [31:0] R2 = 32'h2222_2222;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic [31:0] instr, input logic [31:0] pc,
                       input logic [31:0] rs1, input logic [31:0] rs2,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] ctrl, input logic ill);
        vec_t v;
        v.instr = instr; v.pc = pc; v.rs1 = rs1; v.rs2 = rs2;
        v.a = a; v.b = b; v.ctrl = ctrl; v.ill = ill;
        tbl.push_back(v);
    endtask

    task automatic init_table();
        add(32'h002081B3, 0, 10, 5, 10, 5, 4'h0, 0);                          // add
        add(32'h402081B3, 0, 10, 5, 10, 5, 4'h1, 0);                          // sub
        add(32'h41F0D093, 0, 32'h80000000, R2, 32'h80000000, 31, 4'h7, 0);    // srai 31
        add(32'hDEADB2B7, 0, R1, R2, 0, 32'hDEADB000, 4'hA, 0);               // lui
        add(32'h0020C063, 0, 32'hFFFFFFFB, 3, 32'hFFFFFFFB, 3, 4'h8, 0);      // blt
        add(32'h0020F063, 0, R1, R2, R1, R2, 4'h9, 0);                        // bgeu
        add(32'h022081B3, 0, R1, R2, 0, 0, 4'h0, 1);                          // mul: illegal
        add(32'hFFF00093, 0, 7, R2, 7, 32'hFFFFFFFF, 4'h0, 0);                // addi -1
        add(32'h12345297, 32'h1000, R1, R2, 32'h1000, 32'h12345000, 4'h0, 0); // auipc
        add(32'h008000EF, 32'h2000, R1, R2, 32'h2000, 8, 4'h0, 0);            // jal +8
        add(32'hFFDFF06F, 32'h3000, R1, R2, 32'h3000, 32'hFFFFFFFC, 4'h0, 0); // jal -4
        add(32'hFE20AC23, 0, 32'h100, R2, 32'h100, 32'hFFFFFFF8, 4'h0, 0);    // sw -8
        add(32'h0040A183, 0, 32'h200, R2, 32'h200, 4, 4'h0, 0);               // lw 4
        add(32'h0020B1B3, 0, R1, R2, R1, R2, 4'h9, 0);                        // sltu
        add(32'h0020D1B3, 0, R1, R2, R1, R2, 4'h6, 0);                        // srl
        add(32'h4020D1B3, 0, R1, R2, R1, R2, 4'h7, 0);                        // sra
        add(32'h0020F1B3, 0, R1, R2, R1, R2, 4'h2, 0);                        // and
        add(32'h0020E1B3, 0, R1, R2, R1, R2, 4'h3, 0);                        // or
        add(32'h0020C1B3, 0, R1, R2, R1, R2, 4'h4, 0);                        // xor
        add(32'h002091B3, 0, R1, R2, R1, R2, 4'h5, 0);                        // sll
        add(32'h0020A1B3, 0, R1, R2, R1, R2, 4'h8, 0);                        // slt
        add(32'h02009093, 0, R1, R2, 0, 0, 4'h0, 1);                          // slli bad f7
        add(32'h00309093, 0, R1, R2, R1, 3, 4'h5, 0);                         // slli 3
        add(32'h0FF0C093, 0, R1, R2, R1, 32'hFF, 4'h4, 0);                    // xori
        add(32'h000090E7, 0, R1, R2, 0, 0, 4'h0, 1);                          // jalr f3=1
        add(32'h010080E7, 0, 32'h400, R2, 32'h400, 16, 4'h0, 0);              // jalr 16
        add(32'h0020A063, 0, R1, R2, 0, 0, 4'h0, 1);                          // branch f3=2
        add(32'h00208063, 0, R1, R2, R1, R2, 4'h1, 0);                        // beq
        add(32'h0000007F, 0, R1, R2, 0, 0, 4'h0, 1);                          // bad opcode
        add(32'h402091B3, 0, R1, R2, 0, 0, 4'h0, 1);                          // alt f7, f3=1
        add(32'hFFF0B093, 0, R1, R2, R1, 32'hFFFFFFFF, 4'h9, 0);              // sltiu -1
        add(32'h4000D093, 0, R1, R2, R1, 0, 4'h7, 0);                         // srai 0
        add(32'h2000D093, 0, R1, R2, 0, 0, 4'h0, 1);                          // srli bad f7
        add(32'h40008093, 0, R1, R2, R1, 32'h400, 4'h0, 0);                   // addi 1024
        add(32'h8000A093, 0, R1, R2, R1, 32'hFFFFF800, 4'h8, 0);              // slti -2048
        add(32'h00F0F093, 0, R1, R2, R1, 32'hF, 4'h2, 0);                     // andi
        add(32'h00F0E093, 0, R1, R2, R1, 32'hF, 4'h3, 0);                     // ori
    endtask

    // All stimulus is applied 1ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int idx);
        int guard;
        bit acc;
        vec_t v;
        v = tbl[idx];
        ifc.instr    = v.instr;
        ifc.pc       = v.pc;
        ifc.rs1_data = v.rs1;
        ifc.rs2_data = v.rs2;
        ifc.in_valid = 1'b1;
        guard = 0;
        acc   = 1'b0;
        while (!acc && guard < 200) begin
            acc = ifc.in_ready;
            if (acc) sb.push_back({v.ill, v.ctrl, v.a, v.b});
            step();
            guard++;
        end
        if (!acc) chk("send_timeout", 0, 1);
        ifc.in_valid = 1'b0;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (sb.size() != 0 && guard < 200) begin
            step();
            guard++;
        end
        chk("drain_left", sb.size(), 0);
    endtask

    // Downstream ready driver, applied 2ns after the edge so mode changes
    // made by the main process at +1ns take effect in the same cycle.
    initial begin
        ifc.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            case (ready_mode)
                0:       ifc.out_ready = 1'b1;
                1:       ifc.out_ready = 1'b0;
                default: ifc.out_ready = ($urandom_range(0, 2) != 0);
            endcase
        end
    end

    // Monitor: pops the scoreboard on every output transfer and checks
    // that a stalled output holds its payload.
    initial begin
        logic        stall_prev;
        logic [68:0] prev_pay;
        logic [68:0] cur_pay;
        logic [68:0] e;
        stall_prev = 1'b0;
        prev_pay   = '0;
        forever begin
            @(negedge clk);
            cur_pay = {ifc.illegal, ifc.alu_control, ifc.alu_a, ifc.alu_b};
            if (rst) begin
                stall_prev = 1'b0;
            end else begin
                if (stall_prev) begin
                    chk("stall_valid", ifc.out_valid, 1);
                    chk("stall_payload", cur_pay, prev_pay);
                end
                if (ifc.out_valid && ifc.out_ready) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_output", cur_pay, 69'h0 - 1);
                    end else begin
                        e = sb.pop_front();
                        chk("out_illegal", ifc.illegal, e[68]);
                        chk("out_ctrl", ifc.alu_control, e[67:64]);
                        chk("out_a", ifc.alu_a, e[63:32]);
                        chk("out_b", ifc.alu_b, e[31:0]);
                    end
                end
                stall_prev = ifc.out_valid && !ifc.out_ready;
                prev_pay   = cur_pay;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        init_table();
        rst          = 1'b1;
        ifc.in_valid = 1'b0;
        ifc.instr    = '0;
        ifc.pc       = '0;
        ifc.rs1_data = '0;
        ifc.rs2_data = '0;
        repeat (3) step();
        rst = 1'b0;

        chk("rst_out_valid", ifc.out_valid, 0);
        chk("rst_in_ready", ifc.in_ready, 1);
        chk("rst_payload", {ifc.illegal, ifc.alu_control, ifc.alu_a, ifc.alu_b}, 0);

        // Directed decode, unstalled: one-cycle latency on the first item
        send(0);
        chk("latency_valid", ifc.out_valid, 1);
        for (int i = 1; i < tbl.size(); i++) send(i);
        drain();

        // Backpressure: two accepted, third held until downstream drains
        ready_mode = 1;
        step();
        send(0);
        send(1);
        chk("bp_in_ready_low", ifc.in_ready, 0);
        ifc.instr    = tbl[2].instr;
        ifc.pc       = tbl[2].pc;
        ifc.rs1_data = tbl[2].rs1;
        ifc.rs2_data = tbl[2].rs2;
        ifc.in_valid = 1'b1;
        repeat (3) begin
            step();
            chk("bp_held", ifc.in_ready, 0);
        end
        chk("bp_head_ctrl", ifc.alu_control, 4'h0);
        ready_mode = 0;
        send(2);
        drain();

        // Random handshake over the directed table
        ready_mode = 2;
        for (int n = 0; n < 1000; n++) begin
            int gap;
            gap = $urandom_range(0, 2);
            repeat (gap) begin
                ifc.in_valid = 1'b0;
                ifc.instr    = $urandom;
                step();
            end
            send($urandom_range(0, tbl.size() - 1));
        end
        ready_mode = 0;
        drain();

        // Reset with both registers full and a transfer pending
        ready_mode = 1;
        step();
        send(3);
        send(4);
        chk("full_in_ready", ifc.in_ready, 0);
        rst          = 1'b1;
        ready_mode   = 0;
        ifc.in_valid = 1'b1;
        ifc.instr    = tbl[5].instr;
        sb.delete();
        step();
        rst          = 1'b0;
        ifc.in_valid = 1'b0;
        chk("rst2_out_valid", ifc.out_valid, 0);
        chk("rst2_in_ready", ifc.in_ready, 1);
        chk("rst2_payload", {ifc.illegal, ifc.alu_control, ifc.alu_a, ifc.alu_b}, 0);
        repeat (2) step();
        chk("rst2_idle", ifc.out_valid, 0);
        send(7);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/alu_issue.md
Name: alu_issue

Overview:
Issue-side driver for the datapath ALU. Accepts one decoded-stage RV32I instruction per handshake, together with its register operands and PC. From these it produces the ALU operand pair `alu_a`/`alu_b` and the 4-bit `alu_control` code, and presents them to the execute stage through a registered valid/ready output backed by a 2-entry skid buffer. It is the producer of the exact control encoding the ALU consumes.

Parameters:
XLEN, 32, datapath width; only 32 is supported.

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
in_valid  input  1  upstream presents an instruction
in_ready  output  1  block can accept an instruction this cycle
instr  input  32  raw RV32I instruction word
pc  input  32  address of instr
rs1_data  input  32  value of register rs1
rs2_data  input  32  value of register rs2
out_valid  output  1  alu_a/alu_b/alu_control/illegal are valid
out_ready  input  1  execute stage accepts output
alu_a  output  32  ALU operand a
alu_b  output  32  ALU operand b
alu_control  output  4  ALU op code
illegal  output  1  instruction not decodable by this block

Behaviour:
- ALU codes: ADD=0000, SUB=0001, AND=0010, OR=0011, XOR=0100, SLL=0101, SRL=0110, SRA=0111, SLT=1000, SLTU=1001, PASSB=1010 (result=b).
- Decode, combinational before the output register:
  - OP 0110011: a=rs1, b=rs2.
    - funct7=0000000: funct3 000 ADD, 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL, 110 OR, 111 AND.
    - funct7=0100000: funct3 000 SUB, 101 SRA.
    - Any other funct7/funct3 pair is illegal.
  - OP-IMM 0010011: a=rs1, b=sign-extended I-imm. Same funct3 map, with no SUB.
    - Shifts: b={27'b0, instr[24:20]}.
    - SLLI and SRLI require instr[31:25]=0000000; SRAI requires 0100000. Anything else is illegal.
  - LUI 0110111: a=0, b={instr[31:12],12'b0}, PASSB.
  - AUIPC 0010111: a=pc, b=U-imm, ADD.
  - JAL 1101111: a=pc, b=sign-extended J-imm, ADD.
  - JALR 1100111 (funct3 must be 000): a=rs1, b=I-imm, ADD.
  - LOAD 0000011: a=rs1, b=I-imm, ADD.
  - STORE 0100011: a=rs1, b=sign-extended S-imm, ADD.
  - BRANCH 1100011: a=rs1, b=rs2.
    - funct3 000/001 → SUB.
    - funct3 100/101 → SLT.
    - funct3 110/111 → SLTU.
    - funct3 010/011 are illegal.
  - Any other opcode is illegal.
  - Illegal outputs: illegal=1, alu_control=ADD, alu_a=alu_b=0. Illegal items still flow through the handshake like any other.
- Storage: output register (out_valid plus payload) and skid register (skid_valid plus payload).
- in_ready = !skid_valid, driven from a register only, never combinationally from out_ready.
- Transfer in: occurs when in_valid && in_ready. Transfer out: occurs when out_valid && out_ready.
- Per cycle, with one item accepted in:
  - Output register empty, or being drained this cycle: the new item goes to the output register.
  - Output register full and not draining: the new item goes to skid, and in_ready drops next cycle.
- Per cycle, skid_valid and output draining: the skid item moves to the output register, and skid_valid clears.
  - If an input transfer is impossible in the same cycle (in_ready=0), no item is lost.
- Order is strictly FIFO. Latency in→out is 1 cycle when unstalled. Throughput is 1 per cycle with out_ready held high.
- Output payload is stable while out_valid && !out_ready.
- Reset (synchronous, active-high, overrides all activity including a mid-handshake transfer):
  - out_valid=0, skid_valid=0, in_ready=1.
  - alu_a=0, alu_b=0, alu_control=0000, illegal=0.
  - Any buffered items are discarded.
- Upstream may change instr while in_valid=0; no state changes without a transfer.

Test Plan:
- After rst, send 0x002081B3 (add x3,x1,x2) with rs1=10, rs2=5 and out_ready=1 → next cycle out_valid=1, a=10, b=5, ctrl=0000, illegal=0. Then send 0x402081B3 → ctrl=0001.
- 0x41F0D093 (srai x1,x1,31) with rs1=0x80000000 → a=0x80000000, b=31, ctrl=0111. 0xDEADB2B7 (lui) → a=0, b=0xDEADB000, ctrl=1010.
- BLT (funct3=100, opcode 1100011) with rs1=-5, rs2=3 → ctrl=1000. BGEU → ctrl=1001. OP with funct7=0000001 → illegal=1, ctrl=0000, a=b=0.
- Backpressure:
  - Hold out_ready=0 and stream 3 instructions with in_valid=1 → items 1 and 2 are accepted, then in_ready=0 and item 3 is held.
  - Release out_ready → outputs appear in order 1,2,3, with none lost or duplicated.
  - Output payload is stable while stalled.
- Random valid/ready toggling over 1000 instructions → output sequence matches the reference decode model in order.
- Assert rst with both registers full → next cycle out_valid=0, in_ready=1, and all outputs are zero.
